// File: rtl/dds_voice_bank.sv
// Multi-voice DDS oscillator: per-voice phase accumulators time-multiplexed through one
// interpolating sine LUT pair, summed into a signed saturated 12-bit mix per sample_tick.

module sine_lut (
   input  logic        clk,
   input  logic [14:0] addr,
   output logic [11:0] dout
);
   // Parabolic half-wave approximation: 2048 +/- floor(u*(16383-u)/2^15), peak 2047.
   function automatic logic [11:0] wave(input logic [14:0] a);
      logic [13:0] u;
      logic [27:0] prod;
      logic [11:0] p;
      u    = a[13:0];
      prod = 28'(u) * 28'(14'd16383 - u);
      p    = 12'(prod >> 15);
      return a[14] ? (12'd2048 - p) : (12'd2048 + p);
   endfunction

   always_ff @(posedge clk) begin
      dout <= wave(addr);
   end
endmodule

module dds_voice_bank #(
   parameter int N_VOICES  = 4,
   parameter int PHASE_W   = 18,
   parameter int MIX_SHIFT = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_tick,
   input  logic                        cfg_we,
   input  logic [$clog2(N_VOICES)+1:0] cfg_addr,
   input  logic [PHASE_W-1:0]          cfg_wdata,
   output logic signed [11:0]          mix_out,
   output logic                        mix_valid,
   output logic                        busy,
   output logic                        overrun
);
   localparam int VW     = $clog2(N_VOICES);
   localparam int R      = PHASE_W - 15;
   localparam int DATA_W = 12;
   localparam int ACC_W  = DATA_W + VW;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic logic [DATA_W-1:0] form_sample(
      input logic [1:0]          mode,
      input logic [DATA_W-1:0]   a,
      input logic [DATA_W-1:0]   b,
      input logic [R-1:0]        r,
      input logic [PHASE_W-1:0]  ph
   );
      logic [R:0]          w;
      logic [DATA_W+R:0]   interp;
      logic [DATA_W-1:0]   tri_v;
      logic [DATA_W-1:0]   s;
      w      = (R+1)'(2**R) - (R+1)'(r);
      interp = (DATA_W+R+1)'(a) * (DATA_W+R+1)'(w) + (DATA_W+R+1)'(b) * (DATA_W+R+1)'(r);
      tri_v  = ph[PHASE_W-2 -: DATA_W];
      case (mode)
         2'd0:    s = DATA_W'(interp >> R);
         2'd1:    s = ph[PHASE_W-1] ? '0 : '1;
         2'd2:    s = ph[PHASE_W-1 -: DATA_W];
         default: s = ph[PHASE_W-1] ? ~tri_v : tri_v;
      endcase
      return s;
   endfunction

   function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] y;
      logic signed [DATA_W-1:0] res;
      y = acc >>> MIX_SHIFT;
      if (y > $signed(ACC_W'(2047)))
         res = 12'sd2047;
      else if (y < $signed(ACC_W'(-2048)))
         res = -12'sd2048;
      else
         res = DATA_W'(y);
      return res;
   endfunction

   logic [PHASE_W-1:0] phase_q [N_VOICES];
   logic [PHASE_W-1:0] ftw_q   [N_VOICES];
   logic [1:0]         mode_q  [N_VOICES];
   logic               en_q    [N_VOICES];

   state_t        state_q, state_d;
   logic [VW-1:0] vidx_q, vidx_d;
   logic [1:0]    dcnt_q, dcnt_d;
   logic          issue_p0, frame_start, drain_done;

   logic [VW-1:0] cfg_voice;
   logic [1:0]    cfg_reg;

   logic [PHASE_W-1:0]      phase_p0, phase_p1;
   logic [14:0]             addr_a_p0, addr_b_p0;
   logic [DATA_W-1:0]       lut_a_p1, lut_b_p1;
   logic [1:0]              mode_p1;
   logic                    en_p1, en_p2;
   logic                    vld_p1, vld_p2;
   logic [DATA_W-1:0]       s_p2;
   logic signed [ACC_W-1:0] term_p2, acc_p3;

   assign cfg_voice  = cfg_addr[VW+1:2];
   assign cfg_reg    = cfg_addr[1:0];
   assign busy       = (state_q != IDLE);
   assign drain_done = (state_q == DRAIN) && (dcnt_q == 2'd2);

   always_comb begin
      state_d     = state_q;
      vidx_d      = vidx_q;
      dcnt_d      = dcnt_q;
      issue_p0    = 1'b0;
      frame_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_tick) begin
               state_d     = RUN;
               vidx_d      = '0;
               frame_start = 1'b1;
            end
         end
         RUN: begin
            issue_p0 = 1'b1;
            vidx_d   = vidx_q + 1'b1;
            if (vidx_q == VW'(N_VOICES - 1)) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         vidx_q    <= '0;
         dcnt_q    <= '0;
         overrun   <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         mix_valid <= 1'b0;
         mix_out   <= '0;
      end else begin
         state_q   <= state_d;
         vidx_q    <= vidx_d;
         dcnt_q    <= dcnt_d;
         overrun   <= sample_tick && busy;
         vld_p1    <= issue_p0;
         vld_p2    <= vld_p1;
         mix_valid <= drain_done;
         if (drain_done)
            mix_out <= saturate(acc_p3);
      end
   end

   // Config writes land after the issue-time phase step, so a same-cycle reg2 write wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < N_VOICES; v++) begin
            phase_q[v] <= '0;
            ftw_q[v]   <= '0;
            mode_q[v]  <= '0;
            en_q[v]    <= 1'b0;
         end
      end else begin
         if (issue_p0 && en_q[vidx_q])
            phase_q[vidx_q] <= phase_q[vidx_q] + ftw_q[vidx_q];
         if (cfg_we) begin
            case (cfg_reg)
               2'd0: ftw_q[cfg_voice] <= cfg_wdata;
               2'd1: begin
                  en_q[cfg_voice]   <= cfg_wdata[2];
                  mode_q[cfg_voice] <= cfg_wdata[1:0];
               end
               2'd2: phase_q[cfg_voice] <= cfg_wdata;
               default: ;
            endcase
         end
      end
   end

   // S0: LUT addresses from the pre-update phase
   assign phase_p0  = phase_q[vidx_q];
   assign addr_a_p0 = phase_p0[PHASE_W-1:R];
   assign addr_b_p0 = addr_a_p0 + 15'd1;

   sine_lut u_lut_a (.clk(clk), .addr(addr_a_p0), .dout(lut_a_p1));
   sine_lut u_lut_b (.clk(clk), .addr(addr_b_p0), .dout(lut_b_p1));

   // S1: LUT data valid, form the per-voice sample
   // S2: accumulate centred sample into the frame sum
   assign term_p2 = ACC_W'(s_p2) - ACC_W'(2048);

   always_ff @(posedge clk) begin
      phase_p1 <= phase_p0;
      mode_p1  <= mode_q[vidx_q];
      en_p1    <= en_q[vidx_q];
      s_p2     <= form_sample(mode_p1, lut_a_p1, lut_b_p1, phase_p1[R-1:0], phase_p1);
      en_p2    <= en_p1;
      if (frame_start)
         acc_p3 <= '0;
      else if (vld_p2 && en_p2)
         acc_p3 <= acc_p3 + term_p2;
   end
endmodule

// File: tb/tb_dds_voice_bank.sv
// Bench for dds_voice_bank: directed spec scenarios plus randomized voice settings,
// checked against an arithmetic frame model for MIX_SHIFT=0 and MIX_SHIFT=2 instances.

module tb_dds_voice_bank;
   localparam int N   = 4;
   localparam int PW  = 18;
   localparam int R   = PW - 15;
   localparam int LAT = N + 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           sample_tick = 1'b0;
   logic           cfg_we = 1'b0;
   logic [3:0]     cfg_addr = '0;
   logic [PW-1:0]  cfg_wdata = '0;
   logic signed [11:0] mix_out, mix_out2;
   logic           mix_valid, mix_valid2, busy, busy2, overrun, overrun2;

   int checks = 0;
   int errors = 0;
   int m_phase [N];
   int m_ftw   [N];
   int m_mode  [N];
   int m_en    [N];
   int exp0, exp2;

   always #5 clk = ~clk;

   dds_voice_bank #(.N_VOICES(N), .PHASE_W(PW), .MIX_SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .mix_out(mix_out),
      .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
   );

   dds_voice_bank #(.N_VOICES(N), .PHASE_W(PW), .MIX_SHIFT(2)) dut2 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .mix_out(mix_out2),
      .mix_valid(mix_valid2), .busy(busy2), .overrun(overrun2)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Sine table contents: 2048 +/- floor(u*(16383-u)/32768) over each half-wave.
   function automatic int lut_ref(input int k);
      int u, p;
      u = k % 16384;
      p = (u * (16383 - u)) / 32768;
      return (k >= 16384) ? 2048 - p : 2048 + p;
   endfunction

   function automatic int sample_ref(input int mode, input int ph);
      int a, b, r, msb, t;
      msb = ph / (1 << (PW - 1));
      case (mode)
         0: begin
            a = ph / (1 << R);
            b = (a + 1) % 32768;
            r = ph % (1 << R);
            return (lut_ref(a) * ((1 << R) - r) + lut_ref(b) * r) / (1 << R);
         end
         1: return msb ? 0 : 4095;
         2: return ph / (1 << (PW - 12));
         default: begin
            t = (ph / (1 << (PW - 13))) % 4096;
            return msb ? 4095 - t : t;
         end
      endcase
   endfunction

   function automatic int sat(input int y);
      if (y > 2047) return 2047;
      if (y < -2048) return -2048;
      return y;
   endfunction

   task automatic model_frame();
      int sum = 0;
      for (int v = 0; v < N; v++) begin
         if (m_en[v] != 0) begin
            sum += sample_ref(m_mode[v], m_phase[v]) - 2048;
            m_phase[v] = (m_phase[v] + m_ftw[v]) % (1 << PW);
         end
      end
      exp0 = sat(sum);
      exp2 = sat(sum >>> 2);
   endtask

   task automatic model_reset();
      for (int v = 0; v < N; v++) begin
         m_phase[v] = 0; m_ftw[v] = 0; m_mode[v] = 0; m_en[v] = 0;
      end
   endtask

   task automatic cfg(input int v, input int rg, input int data);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = {2'(v), 2'(rg)};
      cfg_wdata = PW'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      case (rg)
         0: m_ftw[v] = data;
         1: begin m_en[v] = (data >> 2) & 1; m_mode[v] = data & 3; end
         2: m_phase[v] = data;
         default: ;
      endcase
   endtask

   task automatic launch_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic await_mix(input string tag, input int c0);
      int c = c0;
      bit got = 1'b0;
      while (!got && c < 64) begin
         @(posedge clk); #1;
         c++;
         got = mix_valid;
      end
      chk({tag, ":lat"}, c, LAT);
      chk({tag, ":v2"}, mix_valid2, 1);
      chk({tag, ":mix"}, mix_out, exp0);
      chk({tag, ":mix2"}, mix_out2, exp2);
      @(posedge clk); #1;
      chk({tag, ":pulse"}, mix_valid, 0);
      chk({tag, ":idle"}, busy, 0);
   endtask

   task automatic run_frame(input string tag);
      model_frame();
      launch_tick();
      await_mix(tag, 0);
   endtask

   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cnt += int'(mix_valid);
      end
   endtask

   initial begin
      int cnt;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mix", mix_out, 0);
      chk("rst_valid", mix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b0;

      // voice0 sine ftw=8, four frames
      cfg(0, 0, 8);
      cfg(0, 1, 4);
      for (int k = 0; k < 4; k++) run_frame($sformatf("sine8_%0d", k));

      // ftw=4: second frame sits half-way between lut[0] and lut[1]
      cfg(0, 2, 0);
      cfg(0, 0, 4);
      run_frame("sine4_0");
      run_frame("sine4_1");

      // wrap across address 32767 -> 0
      cfg(0, 2, (1 << PW) - 4);
      cfg(0, 0, 8);
      run_frame("wrap_0");
      run_frame("wrap_1");

      // reserved register write has no effect
      cfg(0, 3, 12345);
      cfg(1, 3, 7);
      run_frame("reg3");

      // randomized voice settings
      for (int cfgi = 0; cfgi < 5; cfgi++) begin
         for (int v = 0; v < N; v++) begin
            cfg(v, 0, int'($urandom_range(0, (1 << PW) - 1)));
            cfg(v, 1, int'($urandom_range(0, 7)));
            cfg(v, 2, int'($urandom_range(0, (1 << PW) - 1)));
         end
         for (int f = 0; f < 5; f++) run_frame($sformatf("rand_%0d_%0d", cfgi, f));
      end

      // tick two cycles after a tick: one overrun pulse, one mix
      model_frame();
      launch_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(posedge clk); #1;
      chk("ovr_pulse", overrun, 1);
      chk("ovr_busy", busy, 1);
      @(negedge clk);
      sample_tick = 1'b0;
      @(posedge clk); #1;
      chk("ovr_one", overrun, 0);
      await_mix("ovr_frame", 3);
      count_valid(2 * LAT, cnt);
      chk("ovr_no_extra", cnt, 0);

      // tick on the mix_valid cycle is also an overrun
      model_frame();
      launch_tick();
      repeat (LAT) @(posedge clk);
      #1;
      chk("mvt_valid", mix_valid, 1);
      chk("mvt_mix", mix_out, exp0);
      @(negedge clk);
      sample_tick = 1'b1;
      @(posedge clk); #1;
      chk("mvt_overrun", overrun, 1);
      chk("mvt_idle", busy, 0);
      @(negedge clk);
      sample_tick = 1'b0;
      count_valid(2 * LAT, cnt);
      chk("mvt_no_frame", cnt, 0);

      // four square voices: saturation both ways
      for (int v = 0; v < N; v++) begin
         cfg(v, 1, 5);
         cfg(v, 0, 0);
         cfg(v, 2, 0);
      end
      run_frame("sq_hi");
      for (int v = 0; v < N; v++) cfg(v, 2, 1 << (PW - 1));
      run_frame("sq_lo");

      // reset mid-RUN
      launch_tick();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_mix", mix_out, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_valid", mix_valid, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      count_valid(LAT + 4, cnt);
      chk("mrst_no_valid", cnt, 0);
      run_frame("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
